module_status_monitor: RTL

Synthesizable, parametrised per-module activity monitor that observes the ap_start/ap_ready/ap_done/ap_continue handshake of NUM_CH HLS submodules and accumulates event counts, busy/stall cycles and transaction latency in hardware. It replaces per-instance testbench monitors with one on-chip block usable in simulation and on the board. Counters freeze on `finish` and are read out via a registered request/response port.

---
 rtl/module_status_monitor.sv | 260 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/module_status_monitor.sv
// Per-channel activity monitor for ap_start/ap_ready/ap_done/ap_continue handshakes with a registered readout port.
// Define MSTAT_LATENCY_EN to build the per-channel latency registers (current, last, max).
module module_status_monitor #(
    parameter int                NUM_CH    = 8,
    parameter int                CNT_W     = 32,
    parameter logic [NUM_CH-1:0] CONT_MASK = {NUM_CH{1'b0}},
    parameter int                CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ap_start,
    input  logic [NUM_CH-1:0] ap_ready,
    input  logic [NUM_CH-1:0] ap_done,
    input  logic [NUM_CH-1:0] ap_continue,
    input  logic              finish,
    input  logic              clr,
    input  logic              rd_req,
    input  logic [CH_W-1:0]   rd_ch,
    input  logic [2:0]        rd_sel,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  rd_data,
    output logic [NUM_CH-1:0] overflow,
    output logic              frozen
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_BUSY      = 2'd1,
        ST_DONE_WAIT = 2'd2
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic sat_hit(input logic inc, input logic [CNT_W-1:0] v);
        return inc & (&v);
    endfunction

    logic             frozen_q, frozen_d;
    logic             hold;
    logic             rd_valid_q, rd_valid_d;
    logic [CNT_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0] rd_mux;
    logic [CNT_W-1:0] ch_rd [NUM_CH];

    // The sampling edge of finish already holds everything, not only the following cycles.
    assign hold = finish | frozen_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] start_q, start_d;
        logic [CNT_W-1:0] done_q, done_d;
        logic [CNT_W-1:0] ready_q, ready_d;
        logic [CNT_W-1:0] busy_q, busy_d;
        logic [CNT_W-1:0] stall_q, stall_d;
        logic             ovf_q, ovf_d;
        logic             cont;
        logic             inc_start, inc_done, inc_busy, inc_stall;
        logic [3:0]       status;
        logic [CNT_W-1:0] rd_val;

        assign cont = CONT_MASK[g] ? ap_continue[g] : 1'b1;

`ifdef MSTAT_LATENCY_EN
        logic [CNT_W-1:0] lat_cur_q, lat_cur_d;
        logic [CNT_W-1:0] lat_last_q, lat_last_d;
        logic [CNT_W-1:0] lat_max_q, lat_max_d;
        logic [CNT_W-1:0] lat_now;
        logic             lat_sat;

        // lat_now includes the done cycle, so a start at t and done at t+k gives k+1.
        assign lat_now = sat_inc(lat_cur_q);
        assign lat_sat = (state_q == ST_BUSY) && (&lat_cur_q);

        always_comb begin
            lat_cur_d  = lat_cur_q;
            lat_last_d = lat_last_q;
            lat_max_d  = lat_max_q;
            if (clr) begin
                lat_cur_d  = '0;
                lat_last_d = '0;
                lat_max_d  = '0;
            end else if (!hold) begin
                if (state_q == ST_IDLE && ap_start[g]) begin
                    lat_cur_d = CNT_W'(1);
                end else if (state_q == ST_BUSY) begin
                    lat_cur_d = lat_now;
                    if (ap_done[g]) begin
                        lat_last_d = lat_now;
                        if (lat_now > lat_max_q) begin
                            lat_max_d = lat_now;
                        end
                        if (cont && ap_start[g]) begin
                            lat_cur_d = CNT_W'(1);
                        end
                    end
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lat_cur_q  <= '0;
                lat_last_q <= '0;
                lat_max_q  <= '0;
            end else begin
                lat_cur_q  <= lat_cur_d;
                lat_last_q <= lat_last_d;
                lat_max_q  <= lat_max_d;
            end
        end
`endif

        always_comb begin
            state_d   = state_q;
            inc_start = 1'b0;
            inc_done  = 1'b0;
            inc_busy  = 1'b0;
            inc_stall = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ap_start[g]) begin
                        state_d   = ST_BUSY;
                        inc_start = 1'b1;
                        inc_busy  = 1'b1;
                    end
                end
                ST_BUSY: begin
                    inc_busy = 1'b1;
                    if (ap_done[g]) begin
                        inc_done = 1'b1;
                        if (!cont) begin
                            state_d = ST_DONE_WAIT;
                        end else if (ap_start[g]) begin
                            inc_start = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_DONE_WAIT: begin
                    inc_stall = 1'b1;
                    if (cont) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            start_d = inc_start   ? sat_inc(start_q) : start_q;
            done_d  = inc_done    ? sat_inc(done_q)  : done_q;
            ready_d = ap_ready[g] ? sat_inc(ready_q) : ready_q;
            busy_d  = inc_busy    ? sat_inc(busy_q)  : busy_q;
            stall_d = inc_stall   ? sat_inc(stall_q) : stall_q;
            ovf_d   = ovf_q
                    | sat_hit(inc_start, start_q)
                    | sat_hit(inc_done, done_q)
                    | sat_hit(ap_ready[g], ready_q)
                    | sat_hit(inc_busy, busy_q)
                    | sat_hit(inc_stall, stall_q);
`ifdef MSTAT_LATENCY_EN
            ovf_d = ovf_d | lat_sat;
`endif

            if (clr) begin
                state_d = ST_IDLE;
                start_d = '0;
                done_d  = '0;
                ready_d = '0;
                busy_d  = '0;
                stall_d = '0;
                ovf_d   = 1'b0;
            end else if (hold) begin
                state_d = state_q;
                start_d = start_q;
                done_d  = done_q;
                ready_d = ready_q;
                busy_d  = busy_q;
                stall_d = stall_q;
                ovf_d   = ovf_q;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= ST_IDLE;
                start_q <= '0;
                done_q  <= '0;
                ready_q <= '0;
                busy_q  <= '0;
                stall_q <= '0;
                ovf_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                start_q <= start_d;
                done_q  <= done_d;
                ready_q <= ready_d;
                busy_q  <= busy_d;
                stall_q <= stall_d;
                ovf_q   <= ovf_d;
            end
        end

        assign status = {frozen_q, ovf_q, state_q};

        always_comb begin
            rd_val = '0;
            case (rd_sel)
                3'd0: rd_val = start_q;
                3'd1: rd_val = done_q;
                3'd2: rd_val = ready_q;
                3'd3: rd_val = busy_q;
                3'd4: rd_val = stall_q;
`ifdef MSTAT_LATENCY_EN
                3'd5: rd_val = lat_last_q;
                3'd6: rd_val = lat_max_q;
`endif
                3'd7: rd_val = CNT_W'(status);
                default: rd_val = '0;
            endcase
        end

        assign ch_rd[g]    = rd_val;
        assign overflow[g] = ovf_q;
    end

    // Channel indices beyond NUM_CH match nothing and read back as zero.
    always_comb begin
        rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rd_ch == CH_W'(c)) begin
                rd_mux = ch_rd[c];
            end
        end
    end

    always_comb begin
        rd_valid_d = rd_req;
        rd_data_d  = rd_req ? rd_mux : '0;
        frozen_d   = clr ? 1'b0 : (frozen_q | finish);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            frozen_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            frozen_q   <= frozen_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign frozen   = frozen_q;

endmodule
